bram_stream_loader: RTL and testbench



---
 rtl/bram_stream_loader.sv | 248 ++++++++++++++++++++++++
 tb/tb_bram_stream_loader.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_stream_loader.sv
// bram_stream_loader
//   Byte-stream command front end for the RV32Core debug BRAM ports. Loads
//   words into the instruction or data BRAM, dumps BRAM contents back out as
//   bytes, and issues the core reset pulse that starts execution.
//
// Ports
//   CPU_CLK, CPU_RST        clock, asynchronous active-high reset
//   IN_Data/Valid/Ready     command and payload byte stream (sink side)
//   OUT_Data/Valid/Ready    dump byte stream (source side)
//   CPU_Debug_InstRAM_*     instruction BRAM debug port (A2 byte addr, WD2, WE2, RD2)
//   CPU_Debug_DataRAM_*     data BRAM debug port (same layout)
//   CPU_CoreRst             active-high reset to RV32Core
//   Busy                    high whenever the FSM is not in IDLE
//
// Command bytes (accepted in IDLE)
//   0x01 load InstRAM, 0x02 load DataRAM, 0x03 dump InstRAM,
//   0x04 dump DataRAM, 0x05 start; anything else is dropped.
//   0x01..0x04 are followed by a 16-bit word count, low byte first.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for a command byte
// CNT_LO  | waiting for word count low byte
// CNT_HI  | waiting for word count high byte
// LOAD    | assembling payload words and writing them to the BRAM
// RD_WAIT | address presented, waiting out the BRAM read latency
// SEND    | emitting the captured word, LSB first
// RSTP    | holding CPU_CoreRst high

module bram_stream_loader #(
  parameter int RST_CYCLES = 5,
  parameter int BRAMWORDS  = 4096
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST,
  input  logic [7:0]  IN_Data,
  input  logic        IN_Valid,
  output logic        IN_Ready,
  output logic [7:0]  OUT_Data,
  output logic        OUT_Valid,
  input  logic        OUT_Ready,
  output logic [31:0] CPU_Debug_InstRAM_A2,
  output logic [31:0] CPU_Debug_InstRAM_WD2,
  output logic [3:0]  CPU_Debug_InstRAM_WE2,
  input  logic [31:0] CPU_Debug_InstRAM_RD2,
  output logic [31:0] CPU_Debug_DataRAM_A2,
  output logic [31:0] CPU_Debug_DataRAM_WD2,
  output logic [3:0]  CPU_Debug_DataRAM_WE2,
  input  logic [31:0] CPU_Debug_DataRAM_RD2,
  output logic        CPU_CoreRst,
  output logic        Busy
);

  localparam logic [31:0] ADDR_LIMIT    = 32'(BRAMWORDS * 4);
  // One cycle for the new address to reach the BRAM plus two cycles of
  // read latency: the timer runs 2 -> 1 -> 0 and the word is captured on
  // the edge that sees zero.
  localparam logic [15:0] RD_TIMER_LOAD = 16'd2;
  localparam logic [15:0] RST_TIMER_LOAD = 16'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    CNT_LO,
    CNT_HI,
    LOAD,
    RD_WAIT,
    SEND,
    RSTP
  } state_t;

  state_t      state;
  logic        selData;   // 1: data BRAM, 0: instruction BRAM
  logic        selDump;   // 1: dump, 0: load
  logic [7:0]  cntLo;
  logic [15:0] wordCnt;   // words remaining, last word when it reads 1
  logic [1:0]  byteIdx;
  logic [31:0] shiftReg;  // load: word assembly, dump: bytes still to send
  logic [15:0] timer;

  logic        inFire;
  logic        outFire;
  logic [15:0] cntFull;
  logic [31:0] rdWord;
  logic [31:0] loadWord;

  assign inFire   = IN_Valid && IN_Ready;
  assign outFire  = OUT_Valid && OUT_Ready;
  assign cntFull  = {IN_Data, cntLo};
  assign rdWord   = selData ? CPU_Debug_DataRAM_RD2 : CPU_Debug_InstRAM_RD2;
  // Little-endian assembly: bytes enter at the top and shift down, so the
  // first byte of the word ends up in [7:0].
  assign loadWord = {IN_Data, shiftReg[31:8]};
  assign Busy     = (state != IDLE);

  function automatic logic [31:0] nextAddr(input logic [31:0] a);
    if (a + 32'd4 >= ADDR_LIMIT) return 32'd0;
    return a + 32'd4;
  endfunction

  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) begin
      state                 <= IDLE;
      selData               <= 1'b0;
      selDump               <= 1'b0;
      cntLo                 <= 8'd0;
      wordCnt               <= 16'd0;
      byteIdx               <= 2'd0;
      shiftReg              <= 32'd0;
      timer                 <= 16'd0;
      IN_Ready              <= 1'b0;
      OUT_Data              <= 8'd0;
      OUT_Valid             <= 1'b0;
      CPU_Debug_InstRAM_A2  <= 32'd0;
      CPU_Debug_InstRAM_WD2 <= 32'd0;
      CPU_Debug_InstRAM_WE2 <= 4'd0;
      CPU_Debug_DataRAM_A2  <= 32'd0;
      CPU_Debug_DataRAM_WD2 <= 32'd0;
      CPU_Debug_DataRAM_WE2 <= 4'd0;
      CPU_CoreRst           <= 1'b0;
    end else begin
      // A write strobe lasts one cycle and always advances its address.
      // Handled outside the state case so the final word of a load still
      // retires after the FSM has already returned to IDLE.
      if (CPU_Debug_InstRAM_WE2 != 4'd0) begin
        CPU_Debug_InstRAM_WE2 <= 4'd0;
        CPU_Debug_InstRAM_A2  <= nextAddr(CPU_Debug_InstRAM_A2);
      end
      if (CPU_Debug_DataRAM_WE2 != 4'd0) begin
        CPU_Debug_DataRAM_WE2 <= 4'd0;
        CPU_Debug_DataRAM_A2  <= nextAddr(CPU_Debug_DataRAM_A2);
      end

      case (state)
        IDLE: begin
          IN_Ready <= 1'b1;
          if (inFire) begin
            case (IN_Data)
              8'h01, 8'h02, 8'h03, 8'h04: begin
                selData <= (IN_Data == 8'h02) || (IN_Data == 8'h04);
                selDump <= (IN_Data == 8'h03) || (IN_Data == 8'h04);
                state   <= CNT_LO;
              end
              8'h05: begin
                CPU_CoreRst <= 1'b1;
                timer       <= RST_TIMER_LOAD;
                IN_Ready    <= 1'b0;
                state       <= RSTP;
              end
              default: ;
            endcase
          end
        end

        CNT_LO: begin
          if (inFire) begin
            cntLo <= IN_Data;
            state <= CNT_HI;
          end
        end

        CNT_HI: begin
          if (inFire) begin
            wordCnt <= cntFull;
            byteIdx <= 2'd0;
            if (cntFull == 16'd0) begin
              state <= IDLE;
            end else begin
              if (selData) CPU_Debug_DataRAM_A2 <= 32'd0;
              else         CPU_Debug_InstRAM_A2 <= 32'd0;
              if (selDump) begin
                timer    <= RD_TIMER_LOAD;
                IN_Ready <= 1'b0;
                state    <= RD_WAIT;
              end else begin
                state <= LOAD;
              end
            end
          end
        end

        LOAD: begin
          if (inFire) begin
            shiftReg <= loadWord;
            byteIdx  <= byteIdx + 2'd1;
            if (byteIdx == 2'd3) begin
              if (selData) begin
                CPU_Debug_DataRAM_WD2 <= loadWord;
                CPU_Debug_DataRAM_WE2 <= 4'hF;
              end else begin
                CPU_Debug_InstRAM_WD2 <= loadWord;
                CPU_Debug_InstRAM_WE2 <= 4'hF;
              end
              wordCnt <= wordCnt - 16'd1;
              if (wordCnt == 16'd1) state <= IDLE;
            end
          end
        end

        RD_WAIT: begin
          if (timer == 16'd0) begin
            shiftReg  <= rdWord;
            OUT_Data  <= rdWord[7:0];
            OUT_Valid <= 1'b1;
            byteIdx   <= 2'd0;
            state     <= SEND;
          end else begin
            timer <= timer - 16'd1;
          end
        end

        SEND: begin
          if (outFire) begin
            if (byteIdx == 2'd3) begin
              OUT_Valid <= 1'b0;
              if (selData) CPU_Debug_DataRAM_A2 <= nextAddr(CPU_Debug_DataRAM_A2);
              else         CPU_Debug_InstRAM_A2 <= nextAddr(CPU_Debug_InstRAM_A2);
              wordCnt <= wordCnt - 16'd1;
              if (wordCnt == 16'd1) begin
                IN_Ready <= 1'b1;
                state    <= IDLE;
              end else begin
                timer <= RD_TIMER_LOAD;
                state <= RD_WAIT;
              end
            end else begin
              OUT_Data <= shiftReg[15:8];
              shiftReg <= {8'h00, shiftReg[31:8]};
              byteIdx  <= byteIdx + 2'd1;
            end
          end
        end

        RSTP: begin
          if (timer == 16'd0) begin
            CPU_CoreRst <= 1'b0;
            IN_Ready    <= 1'b1;
            state       <= IDLE;
          end else begin
            timer <= timer - 16'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_stream_loader.sv
// tb_bram_stream_loader
//   Self-checking bench for bram_stream_loader. Two 2-cycle-latency BRAM
//   models sit on the debug ports; an independent word-array model of the
//   BRAM contents predicts every write and every dumped byte.

module tb_bram_stream_loader;

  localparam int RSTC = 5;
  localparam int BW   = 8;   // small depth so address wrap is reached quickly

  logic        CPU_CLK = 1'b0;
  logic        CPU_RST = 1'b1;
  logic [7:0]  IN_Data = 8'd0;
  logic        IN_Valid = 1'b0;
  logic        IN_Ready;
  logic [7:0]  OUT_Data;
  logic        OUT_Valid;
  logic        OUT_Ready = 1'b1;
  logic [31:0] iA2, iWD2, dA2, dWD2;
  logic [31:0] iRD2 = 32'd0;
  logic [31:0] dRD2 = 32'd0;
  logic [3:0]  iWE2, dWE2;
  logic        CPU_CoreRst, Busy;

  always #5 CPU_CLK = ~CPU_CLK;

  bram_stream_loader #(.RST_CYCLES(RSTC), .BRAMWORDS(BW)) dut (
    .CPU_CLK               (CPU_CLK),
    .CPU_RST               (CPU_RST),
    .IN_Data               (IN_Data),
    .IN_Valid              (IN_Valid),
    .IN_Ready              (IN_Ready),
    .OUT_Data              (OUT_Data),
    .OUT_Valid             (OUT_Valid),
    .OUT_Ready             (OUT_Ready),
    .CPU_Debug_InstRAM_A2  (iA2),
    .CPU_Debug_InstRAM_WD2 (iWD2),
    .CPU_Debug_InstRAM_WE2 (iWE2),
    .CPU_Debug_InstRAM_RD2 (iRD2),
    .CPU_Debug_DataRAM_A2  (dA2),
    .CPU_Debug_DataRAM_WD2 (dWD2),
    .CPU_Debug_DataRAM_WE2 (dWE2),
    .CPU_Debug_DataRAM_RD2 (dRD2),
    .CPU_CoreRst           (CPU_CoreRst),
    .Busy                  (Busy)
  );

  // BRAM models: address registered, then data registered (2-cycle read).
  logic [31:0] iMem [BW] = '{default: 32'h0};
  logic [31:0] dMem [BW] = '{0: 32'hDEADBEEF, default: 32'h0};
  logic [31:0] iAq = 32'd0;
  logic [31:0] dAq = 32'd0;

  always @(posedge CPU_CLK) begin
    if (iWE2 == 4'hF) iMem[iA2[4:2]] <= iWD2;
    if (dWE2 == 4'hF) dMem[dA2[4:2]] <= dWD2;
    iAq  <= iA2;
    dAq  <= dA2;
    iRD2 <= iMem[iAq[4:2]];
    dRD2 <= dMem[dAq[4:2]];
  end

  // Reference contents, updated only from what the bench itself loads.
  logic [31:0] refI [BW] = '{default: 32'h0};
  logic [31:0] refD [BW] = '{0: 32'hDEADBEEF, default: 32'h0};

  int vecs = 0;
  int misses = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t        actI[$];
  wr_t        actD[$];
  logic [7:0] actOut[$];
  int         rstCyc = 0;
  int         rdyInRst = 0;
  int         badWe = 0;

  always @(posedge CPU_CLK) begin
    if (iWE2 != 4'd0) begin
      actI.push_back('{iA2, iWD2});
      if (iWE2 != 4'hF) badWe++;
    end
    if (dWE2 != 4'd0) begin
      actD.push_back('{dA2, dWD2});
      if (dWE2 != 4'hF) badWe++;
    end
    if (OUT_Valid && OUT_Ready) actOut.push_back(OUT_Data);
    if (CPU_CoreRst) begin
      rstCyc++;
      if (IN_Ready) rdyInRst++;
    end
  end

  // A byte offered but not taken must still be offered, unchanged, next edge.
  logic       heldV = 1'b0;
  logic [7:0] heldD = 8'd0;
  always @(posedge CPU_CLK) begin
    if (heldV) begin
      vecs++;
      if (!(OUT_Valid && OUT_Data == heldD)) begin
        misses++;
        $display("FAIL out_hold: valid=%0b data=0x%02h, required valid=1 data=0x%02h",
                 OUT_Valid, OUT_Data, heldD);
      end
    end
    heldV = OUT_Valid && !OUT_Ready && !CPU_RST;
    heldD = OUT_Data;
  end

  // 0: always ready, 1: toggle every cycle, 2: random
  int outMode = 0;
  initial begin
    forever begin
      @(posedge CPU_CLK);
      #1;
      case (outMode)
        0:       OUT_Ready = 1'b1;
        1:       OUT_Ready = ~OUT_Ready;
        default: OUT_Ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      misses++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CPU_CLK);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the handshake edge.
  task automatic sendByte(input logic [7:0] b, input int gapMax);
    int g;
    int guard;
    g = (gapMax > 0) ? int'($urandom_range(0, gapMax)) : 0;
    tick(g);
    IN_Data  = b;
    IN_Valid = 1'b1;
    guard    = 0;
    forever begin
      @(negedge CPU_CLK);
      if (IN_Ready) break;
      guard++;
      if (guard > 200) begin
        vecs++;
        misses++;
        $display("FAIL in_ready_timeout: byte 0x%02h not accepted within 200 cycles", b);
        break;
      end
    end
    @(posedge CPU_CLK);
    #1;
    IN_Valid = 1'b0;
  endtask

  task automatic clearMon();
    actI.delete();
    actD.delete();
    actOut.delete();
    rstCyc   = 0;
    rdyInRst = 0;
    badWe    = 0;
  endtask

  task automatic runTxn(input logic [7:0] cmd, input int n, input logic [31:0] w0,
                        input logic [31:0] w1, input bit rnd, input int gap,
                        output int nI, output int nD, output int nO, output int nR);
    logic [31:0] words[$];
    wr_t         expW[$];
    logic [7:0]  expB[$];
    logic [15:0] n16;
    logic [31:0] w;
    int          idx;
    int          guard;
    bit          isLoad;
    bit          isDump;

    clearMon();
    n16    = 16'(n);
    isLoad = (cmd == 8'h01) || (cmd == 8'h02);
    isDump = (cmd == 8'h03) || (cmd == 8'h04);
    for (int i = 0; i < n; i++) begin
      if (rnd)         words.push_back($urandom);
      else if (i == 0) words.push_back(w0);
      else if (i == 1) words.push_back(w1);
      else             words.push_back(w0 ^ (32'h01010101 * 32'(i)));
    end

    if (isLoad) begin
      for (int i = 0; i < n; i++) begin
        idx = i % BW;
        expW.push_back('{32'(idx * 4), words[i]});
        if (cmd == 8'h01) refI[idx] = words[i];
        else              refD[idx] = words[i];
      end
    end
    if (isDump) begin
      for (int i = 0; i < n; i++) begin
        w = (cmd == 8'h03) ? refI[i % BW] : refD[i % BW];
        for (int b = 0; b < 4; b++) expB.push_back(w[8*b +: 8]);
      end
    end

    sendByte(cmd, gap);
    if (isLoad || isDump) begin
      sendByte(n16[7:0], gap);
      sendByte(n16[15:8], gap);
      if (isLoad) begin
        for (int i = 0; i < n; i++)
          for (int b = 0; b < 4; b++) sendByte(words[i][8*b +: 8], gap);
      end
    end

    guard = 0;
    while (Busy && guard < 3000) begin
      tick(1);
      guard++;
    end
    if (guard >= 3000) begin
      vecs++;
      misses++;
      $display("FAIL busy_timeout: cmd 0x%02h still busy after 3000 cycles", cmd);
    end
    tick(2);

    nI = actI.size();
    nD = actD.size();
    nO = actOut.size();
    nR = rstCyc;

    check("we_full_word", 32'(badWe), 32'd0);
    check("idle_in_ready", {31'd0, IN_Ready}, 32'd1);
    if (isLoad) begin
      for (int i = 0; i < expW.size(); i++) begin
        if (cmd == 8'h01 && i < actI.size()) begin
          check("inst_wr_addr", actI[i].a, expW[i].a);
          check("inst_wr_data", actI[i].d, expW[i].d);
        end
        if (cmd == 8'h02 && i < actD.size()) begin
          check("data_wr_addr", actD[i].a, expW[i].a);
          check("data_wr_data", actD[i].d, expW[i].d);
        end
      end
    end
    if (isDump) begin
      for (int i = 0; i < expB.size() && i < actOut.size(); i++)
        check("dump_byte", {24'd0, actOut[i]}, {24'd0, expB[i]});
    end
    if (cmd == 8'h05) check("in_ready_low_in_pulse", 32'(rdyInRst), 32'd0);
  endtask

  typedef struct {
    logic [7:0]  cmd;
    int          n;
    logic [31:0] w0;
    logic [31:0] w1;
    int          oMode;
    int          expI;
    int          expD;
    int          expO;
    int          expR;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int nI, nD, nO, nR, lat, r, n;
    logic [7:0] cmd;

    tbl[0] = '{8'h01, 2,  32'h00000013, 32'h00100093, 0, 2, 0, 0,  0};
    tbl[1] = '{8'h03, 2,  32'h0,        32'h0,        0, 0, 0, 8,  0};
    tbl[2] = '{8'h04, 1,  32'h0,        32'h0,        1, 0, 0, 4,  0};
    tbl[3] = '{8'h02, 0,  32'h0,        32'h0,        0, 0, 0, 0,  0};
    tbl[4] = '{8'h7F, 0,  32'h0,        32'h0,        0, 0, 0, 0,  0};
    tbl[5] = '{8'h05, 0,  32'h0,        32'h0,        0, 0, 0, 0,  RSTC};
    tbl[6] = '{8'h02, 10, 32'hA5A50000, 32'h5A5A1111, 0, 0, 10, 0, 0};
    tbl[7] = '{8'h04, 10, 32'h0,        32'h0,        2, 0, 0, 40, 0};
    tbl[8] = '{8'h01, 1,  32'hFFFFFFFF, 32'h0,        0, 1, 0, 0,  0};

    // Reset values while reset is held.
    #12;
    check("rst_in_ready", {31'd0, IN_Ready}, 32'd0);
    check("rst_out", {23'd0, OUT_Valid, OUT_Data}, 32'd0);
    check("rst_inst_a2", iA2, 32'd0);
    check("rst_data_a2", dA2, 32'd0);
    check("rst_wd2", iWD2 | dWD2, 32'd0);
    check("rst_we2", {24'd0, iWE2, dWE2}, 32'd0);
    check("rst_corerst_busy", {30'd0, CPU_CoreRst, Busy}, 32'd0);
    @(posedge CPU_CLK);
    #1;
    CPU_RST = 1'b0;
    tick(2);
    check("post_rst_in_ready", {31'd0, IN_Ready}, 32'd1);
    check("post_rst_busy", {31'd0, Busy}, 32'd0);

    // Dump latency and bubble-free byte sequence: DataRAM[0] = DEADBEEF.
    clearMon();
    sendByte(8'h04, 0);
    sendByte(8'h01, 0);
    sendByte(8'h00, 0);
    lat = 0;
    while (!OUT_Valid && lat < 20) begin
      @(posedge CPU_CLK);
      #1;
      lat++;
    end
    check("dump_latency", 32'(lat), 32'd3);
    tick(4);
    check("dump_bytes_no_bubble", 32'(actOut.size()), 32'd4);
    if (actOut.size() == 4)
      check("dump_deadbeef", {actOut[3], actOut[2], actOut[1], actOut[0]}, 32'hDEADBEEF);
    check("dump_back_idle", {31'd0, Busy}, 32'd0);

    // Table-driven transactions.
    for (int t = 0; t < 9; t++) begin
      outMode = tbl[t].oMode;
      runTxn(tbl[t].cmd, tbl[t].n, tbl[t].w0, tbl[t].w1, 1'b0, 0, nI, nD, nO, nR);
      outMode = 0;
      check("tbl_inst_writes", 32'(nI), 32'(tbl[t].expI));
      check("tbl_data_writes", 32'(nD), 32'(tbl[t].expD));
      check("tbl_out_bytes",   32'(nO), 32'(tbl[t].expO));
      check("tbl_corerst_len", 32'(nR), 32'(tbl[t].expR));
      check("tbl_busy_after",  {31'd0, Busy}, 32'd0);
    end

    // Reset in the middle of a load: partial word must be dropped.
    clearMon();
    sendByte(8'h01, 0);
    sendByte(8'h01, 0);
    sendByte(8'h00, 0);
    sendByte(8'hAA, 0);
    sendByte(8'hBB, 0);
    CPU_RST = 1'b1;
    #1;
    check("midload_rst_we2", {28'd0, iWE2}, 32'd0);
    check("midload_rst_a2", iA2, 32'd0);
    check("midload_rst_ready_busy", {30'd0, IN_Ready, Busy}, 32'd0);
    tick(2);
    CPU_RST = 1'b0;
    tick(3);
    check("midload_no_write", 32'(actI.size()), 32'd0);
    runTxn(8'h01, 1, 32'h12345678, 32'h0, 1'b0, 0, nI, nD, nO, nR);
    check("reload_inst_writes", 32'(nI), 32'd1);
    check("reload_data_writes", 32'(nD), 32'd0);

    // Reset cuts a start pulse short.
    sendByte(8'h05, 0);
    tick(2);
    check("pulse_in_progress", {31'd0, CPU_CoreRst}, 32'd1);
    CPU_RST = 1'b1;
    #1;
    check("pulse_cut_by_rst", {31'd0, CPU_CoreRst}, 32'd0);
    tick(2);
    CPU_RST = 1'b0;
    tick(2);

    // Randomised traffic with input gaps and random backpressure.
    for (int k = 0; k < 24; k++) begin
      r   = int'($urandom_range(0, 9));
      cmd = (r < 8) ? 8'(1 + (r % 4)) : 8'h05;
      n   = int'($urandom_range(0, 12));
      outMode = 2;
      runTxn(cmd, n, 32'h0, 32'h0, 1'b1, 2, nI, nD, nO, nR);
      outMode = 0;
      check("rnd_inst_writes", 32'(nI), (cmd == 8'h01) ? 32'(n) : 32'd0);
      check("rnd_data_writes", 32'(nD), (cmd == 8'h02) ? 32'(n) : 32'd0);
      check("rnd_out_bytes", 32'(nO),
            (cmd == 8'h03 || cmd == 8'h04) ? 32'(4 * n) : 32'd0);
      check("rnd_corerst_len", 32'(nR), (cmd == 8'h05) ? 32'(RSTC) : 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, misses);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

endmodule
